// File: rtl/mm_stream_if.sv
// Handshake bundle for mm_stream_core: byte-serial matrix load port plus the
// valid/ready result stream with its status flags.
interface mm_stream_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 12
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     col_end;
    logic                     row_end;
    logic                     busy;
    logic                     out_valid;
    logic                     out_ready;
    logic        [OUT_W-1:0]  out_data;
    logic                     overflow;
    logic                     change_row;
    logic                     is_legal;
    logic        [1:0]        ep;

    modport master (
        output in_valid, in_data, col_end, row_end, out_ready,
        input  busy, out_valid, out_data, overflow, change_row, is_legal, ep
    );

    modport slave (
        input  in_valid, in_data, col_end, row_end, out_ready,
        output busy, out_valid, out_data, overflow, change_row, is_legal, ep
    );
endinterface

// File: rtl/mm_stream_core.sv
// Streaming signed matrix multiplier: loads A then B row-major, checks shapes,
// streams C = A x B with overflow flags. Define MM_SAT_EN to clamp overflowed results.
module mm_stream_core #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 4,
    parameter int OUT_W   = 12,
    parameter int ACC_W   = 2*DATA_W + $clog2(MAX_DIM) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    mm_stream_if.slave  bus
);
    localparam int DEPTH = MAX_DIM * MAX_DIM;
    localparam int AW    = (MAX_DIM > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(MAX_DIM + 2) + 1;
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] DIM_MAX = CW'(MAX_DIM);
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((32'sd1 <<< (OUT_W-1)) - 32'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_CHECK   = 3'd2,
        S_CALC    = 3'd3,
        S_OUT     = 3'd4,
        S_ILLEGAL = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic signed [DATA_W-1:0] a_mem_q [DEPTH];
    logic signed [DATA_W-1:0] a_mem_d [DEPTH];
    logic signed [DATA_W-1:0] b_mem_q [DEPTH];
    logic signed [DATA_W-1:0] b_mem_d [DEPTH];
    logic [CW-1:0]            row_pos_q, row_pos_d;
    logic [CW-1:0]            a_cols_q, a_cols_d, a_rows_q, a_rows_d;
    logic [CW-1:0]            b_cols_q, b_cols_d, b_rows_q, b_rows_d;
    logic [CW-1:0]            i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     busy_q, busy_d, out_valid_q, out_valid_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     overflow_q, overflow_d, change_row_q, change_row_d;
    logic                     is_legal_q, is_legal_d;
    logic [1:0]               ep_q, ep_d;

    logic                       is_a_s, err_s, legal_s;
    logic [CW-1:0]              cur_cols_s, cur_rows_s, row_len_s, new_cols_s, new_rows_s;
    logic signed [DATA_W-1:0]   a_rd_s, b_rd_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    acc_sum_s;

    // Storage is laid out on a fixed MAX_DIM stride so reads need no knowledge of the loaded width.
    function automatic logic [AW-1:0] idx_f(input logic [CW-1:0] r, input logic [CW-1:0] c);
        int t;
        t = int'(r) * MAX_DIM + int'(c);
        return AW'(t);
    endfunction

    function automatic logic ovf_f(input logic signed [ACC_W-1:0] v);
        return (v > OUT_MAX) || (v < OUT_MIN);
    endfunction

    function automatic logic [OUT_W-1:0] fit_f(input logic signed [ACC_W-1:0] v);
`ifdef MM_SAT_EN
        if (v > OUT_MAX) begin
            return OUT_MAX[OUT_W-1:0];
        end else if (v < OUT_MIN) begin
            return OUT_MIN[OUT_W-1:0];
        end else begin
            return v[OUT_W-1:0];
        end
`else
        return v[OUT_W-1:0];
`endif
    endfunction

    // Next-state, datapath and output computation.
    always_comb begin
        state_d      = state_q;
        a_mem_d      = a_mem_q;
        b_mem_d      = b_mem_q;
        row_pos_d    = row_pos_q;
        a_cols_d     = a_cols_q;
        a_rows_d     = a_rows_q;
        b_cols_d     = b_cols_q;
        b_rows_d     = b_rows_q;
        i_d          = i_q;
        j_d          = j_q;
        k_d          = k_q;
        acc_d        = acc_q;
        busy_d       = busy_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        overflow_d   = overflow_q;
        change_row_d = change_row_q;
        is_legal_d   = is_legal_q;
        ep_d         = ep_q;
        err_s        = 1'b0;
        is_a_s       = (state_q == S_LOAD_A);
        cur_cols_s   = is_a_s ? a_cols_q : b_cols_q;
        cur_rows_s   = is_a_s ? a_rows_q : b_rows_q;
        new_cols_s   = cur_cols_s;
        new_rows_s   = cur_rows_s;
        row_len_s    = row_pos_q + ONE_C;
        a_rd_s       = a_mem_q[idx_f(i_q, k_q)];
        b_rd_s       = b_mem_q[idx_f(k_q, j_q)];
        prod_s       = a_rd_s * b_rd_s;
        acc_sum_s    = acc_q + {{(ACC_W-2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};
        legal_s      = (a_cols_q == b_rows_q) && (ep_q == 2'b00);

        case (state_q)
            S_LOAD_A, S_LOAD_B: begin
                if (bus.in_valid && !busy_q) begin
                    // Elements past MAX_DIM in either direction are flagged and discarded.
                    if ((row_pos_q < DIM_MAX) && (cur_rows_s < DIM_MAX)) begin
                        if (is_a_s) begin
                            a_mem_d[idx_f(cur_rows_s, row_pos_q)] = bus.in_data;
                        end else begin
                            b_mem_d[idx_f(cur_rows_s, row_pos_q)] = bus.in_data;
                        end
                    end else begin
                        err_s = 1'b1;
                    end
                    if (bus.col_end || bus.row_end) begin
                        row_pos_d = ZERO_C;
                        if (cur_cols_s == ZERO_C) begin
                            new_cols_s = row_len_s;
                        end else if (row_len_s != cur_cols_s) begin
                            err_s = 1'b1;
                        end else begin
                            new_cols_s = cur_cols_s;
                        end
                        new_rows_s = (cur_rows_s <= DIM_MAX) ? (cur_rows_s + ONE_C) : cur_rows_s;
                        if (bus.row_end) begin
                            state_d = is_a_s ? S_LOAD_B : S_CHECK;
                            busy_d  = !is_a_s;
                        end else begin
                            state_d = state_q;
                        end
                    end else if (row_pos_q < DIM_MAX) begin
                        row_pos_d = row_pos_q + ONE_C;
                    end else begin
                        row_pos_d = row_pos_q;
                    end
                    if (is_a_s) begin
                        a_cols_d = new_cols_s;
                        a_rows_d = new_rows_s;
                        ep_d[0]  = ep_q[0] | err_s;
                    end else begin
                        b_cols_d = new_cols_s;
                        b_rows_d = new_rows_s;
                        ep_d[1]  = ep_q[1] | err_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_CHECK: begin
                is_legal_d = legal_s;
                i_d        = ZERO_C;
                j_d        = ZERO_C;
                k_d        = ZERO_C;
                acc_d      = {ACC_W{1'b0}};
                if (legal_s) begin
                    state_d = S_CALC;
                end else begin
                    state_d      = S_ILLEGAL;
                    out_valid_d  = 1'b1;
                    out_data_d   = {OUT_W{1'b0}};
                    overflow_d   = 1'b0;
                    change_row_d = 1'b0;
                end
            end
            S_CALC: begin
                acc_d = acc_sum_s;
                if (k_q == (a_cols_q - ONE_C)) begin
                    k_d          = ZERO_C;
                    state_d      = S_OUT;
                    out_valid_d  = 1'b1;
                    out_data_d   = fit_f(acc_sum_s);
                    overflow_d   = ovf_f(acc_sum_s);
                    change_row_d = (j_q == (b_cols_q - ONE_C));
                end else begin
                    k_d = k_q + ONE_C;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d  = 1'b0;
                    out_data_d   = {OUT_W{1'b0}};
                    overflow_d   = 1'b0;
                    change_row_d = 1'b0;
                    acc_d        = {ACC_W{1'b0}};
                    if (change_row_q) begin
                        if (i_q == (a_rows_q - ONE_C)) begin
                            state_d = S_FINISH;
                        end else begin
                            i_d     = i_q + ONE_C;
                            j_d     = ZERO_C;
                            state_d = S_CALC;
                        end
                    end else begin
                        j_d     = j_q + ONE_C;
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_ILLEGAL: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_FINISH;
                end else begin
                    state_d = state_q;
                end
            end
            S_FINISH: begin
                row_pos_d  = ZERO_C;
                a_cols_d   = ZERO_C;
                a_rows_d   = ZERO_C;
                b_cols_d   = ZERO_C;
                b_rows_d   = ZERO_C;
                i_d        = ZERO_C;
                j_d        = ZERO_C;
                k_d        = ZERO_C;
                acc_d      = {ACC_W{1'b0}};
                ep_d       = 2'b00;
                is_legal_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = S_LOAD_A;
            end
            default: begin
                state_d = S_LOAD_A;
            end
        endcase
    end

    // Control, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOAD_A;
            row_pos_q    <= ZERO_C;
            a_cols_q     <= ZERO_C;
            a_rows_q     <= ZERO_C;
            b_cols_q     <= ZERO_C;
            b_rows_q     <= ZERO_C;
            i_q          <= ZERO_C;
            j_q          <= ZERO_C;
            k_q          <= ZERO_C;
            acc_q        <= {ACC_W{1'b0}};
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= {OUT_W{1'b0}};
            overflow_q   <= 1'b0;
            change_row_q <= 1'b0;
            is_legal_q   <= 1'b0;
            ep_q         <= 2'b00;
        end else begin
            state_q      <= state_d;
            row_pos_q    <= row_pos_d;
            a_cols_q     <= a_cols_d;
            a_rows_q     <= a_rows_d;
            b_cols_q     <= b_cols_d;
            b_rows_q     <= b_rows_d;
            i_q          <= i_d;
            j_q          <= j_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            overflow_q   <= overflow_d;
            change_row_q <= change_row_d;
            is_legal_q   <= is_legal_d;
            ep_q         <= ep_d;
        end
    end

    // Matrix storage; cleared on reset so reads of unwritten cells are never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < DEPTH; n++) begin
                a_mem_q[n] <= {DATA_W{1'b0}};
                b_mem_q[n] <= {DATA_W{1'b0}};
            end
        end else begin
            a_mem_q <= a_mem_d;
            b_mem_q <= b_mem_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.overflow   = overflow_q;
    assign bus.change_row = change_row_q;
    assign bus.is_legal   = is_legal_q;
    assign bus.ep         = ep_q;
endmodule

// File: tb/tb_mm_stream_core.sv
// Self-checking bench for mm_stream_core: scenario table plus hand-written
// malformed-load and mid-calculation reset sequences, scoreboard on the output stream.
module tb_mm_stream_core;
    localparam int DW   = 8;
    localparam int MD   = 4;
    localparam int OW   = 12;
    localparam int OMAX = (1 << (OW-1)) - 1;
    localparam int OMIN = -(1 << (OW-1));

    typedef struct {
        int         ar, ac, br, bc;
        int         a_base, a_step, b_base, b_step;
        bit         tog;
        logic [1:0] exp_ep;
    } scen_t;

    typedef struct {
        logic [OW-1:0] data;
        logic          ovf;
        logic          cr;
        logic          legal;
        logic [1:0]    ep;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mm_stream_if #(.DATA_W(DW), .OUT_W(OW)) bus ();

    mm_stream_core #(.DATA_W(DW), .MAX_DIM(MD), .OUT_W(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    tog_en   = 1'b0;
    scen_t tbl[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] fit(input int v);
        logic [31:0] t;
`ifdef MM_SAT_EN
        if (v > OMAX) t = 32'(OMAX);
        else if (v < OMIN) t = 32'(OMIN);
        else t = 32'(v);
`else
        t = 32'(v);
`endif
        return t[OW-1:0];
    endfunction

    task automatic push_illegal(input logic [1:0] ep);
        exp_t e;
        e.data = {OW{1'b0}}; e.ovf = 1'b0; e.cr = 1'b0; e.legal = 1'b0; e.ep = ep;
        sb.push_back(e);
    endtask

    task automatic push_expected(input scen_t s);
        exp_t e;
        int   sum;
        if ((s.ac != s.br) || (s.exp_ep != 2'b00)) begin
            push_illegal(s.exp_ep);
        end else begin
            for (int i = 0; i < s.ar; i++) begin
                for (int j = 0; j < s.bc; j++) begin
                    sum = 0;
                    for (int k = 0; k < s.ac; k++)
                        sum += (s.a_base + s.a_step*(i*s.ac + k)) * (s.b_base + s.b_step*(k*s.bc + j));
                    e.data = fit(sum); e.ovf = (sum > OMAX) || (sum < OMIN);
                    e.cr = (j == s.bc - 1); e.legal = 1'b1; e.ep = 2'b00;
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.col_end = 1'b0; bus.row_end = 1'b0; bus.in_data = 8'sd0;
    endtask

    task automatic send_el(input int v, input logic ce, input logic re);
        bus.in_valid = 1'b1; bus.in_data = DW'(v); bus.col_end = ce; bus.row_end = re;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic load_mat(input int rows, input int cols, input int base, input int step);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                send_el(base + step*(r*cols + c), c == cols - 1, (r == rows - 1) && (c == cols - 1));
    endtask

    // Called right after B's last element is accepted; drives junk while busy.
    task automatic finish_run(input bit legal, input int k);
        int lat;
        lat = 0;
        chk("busy_rise", 32'(bus.busy), 32'd1);
        for (int c = 1; c <= 200; c++) begin
            if (c <= 2) begin
                bus.in_valid = 1'b1; bus.in_data = 8'sh55; bus.col_end = 1'b1; bus.row_end = 1'b1;
            end else begin
                idle_inputs();
            end
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = c;
                break;
            end
        end
        idle_inputs();
        chk("first_valid_latency", 32'(lat), legal ? 32'(k + 1) : 32'd1);
        for (int c = 0; c < 3000 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk("drain_results", 32'(sb.size()), 32'd0);
        sb.delete();
        for (int c = 0; c < 10 && bus.busy; c++) begin
            @(posedge clk); #1;
        end
        chk("busy_fall", 32'(bus.busy), 32'd0);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("ep_cleared", 32'(bus.ep), 32'd0);
        tog_en = 1'b0;
    endtask

    task automatic run_scenario(input scen_t s);
        tog_en = s.tog;
        push_expected(s);
        load_mat(s.ar, s.ac, s.a_base, s.a_step);
        load_mat(s.br, s.bc, s.b_base, s.b_step);
        finish_run((s.ac == s.br) && (s.exp_ep == 2'b00), s.ac);
    endtask

    // Consumer: ready is 1 normally, or repeats 1-0-0 when toggling is enabled.
    initial begin
        logic pat [3];
        int   ph;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tog_en) begin
                bus.out_ready = pat[ph % 3];
                ph++;
            end else begin
                bus.out_ready = 1'b1;
                ph = 0;
            end
        end
    end

    // Output monitor: scoreboard pops on handshake, stability checks during stalls.
    initial begin
        exp_t          e;
        logic [OW+1:0] held;
        bit            stall_prev;
        stall_prev = 1'b0;
        held = {(OW+2){1'b0}};
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (stall_prev)
                    chk("stall_stable", 32'({bus.out_data, bus.overflow, bus.change_row}), 32'(held));
                if (bus.out_ready) begin
                    chk("result_expected", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("out_data", 32'(bus.out_data), 32'(e.data));
                        chk("overflow", 32'(bus.overflow), 32'(e.ovf));
                        chk("change_row", 32'(bus.change_row), 32'(e.cr));
                        chk("is_legal", 32'(bus.is_legal), 32'(e.legal));
                        chk("ep", 32'(bus.ep), 32'(e.ep));
                    end
                    stall_prev = 1'b0;
                end else begin
                    held = {bus.out_data, bus.overflow, bus.change_row};
                    stall_prev = 1'b1;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t s;
        idle_inputs();
        tbl[0] = '{ar:2, ac:2, br:2, bc:2, a_base:1,    a_step:1,  b_base:5,   b_step:1,   tog:1'b0, exp_ep:2'b00};
        tbl[1] = '{ar:2, ac:3, br:2, bc:2, a_base:1,    a_step:1,  b_base:1,   b_step:1,   tog:1'b0, exp_ep:2'b00};
        tbl[2] = '{ar:1, ac:4, br:4, bc:1, a_base:127,  a_step:0,  b_base:127, b_step:0,   tog:1'b0, exp_ep:2'b00};
        tbl[3] = '{ar:3, ac:3, br:3, bc:3, a_base:-4,   a_step:1,  b_base:9,   b_step:-2,  tog:1'b1, exp_ep:2'b00};
        tbl[4] = '{ar:4, ac:4, br:4, bc:4, a_base:-128, a_step:17, b_base:127, b_step:-17, tog:1'b0, exp_ep:2'b00};
        tbl[5] = '{ar:1, ac:5, br:5, bc:1, a_base:1,    a_step:1,  b_base:2,   b_step:1,   tog:1'b0, exp_ep:2'b11};
        tbl[6] = '{ar:1, ac:4, br:4, bc:2, a_base:3,    a_step:-2, b_base:-1,  b_step:1,   tog:1'b1, exp_ep:2'b00};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_change_row", 32'(bus.change_row), 32'd0);
        chk("rst_is_legal", 32'(bus.is_legal), 32'd0);
        chk("rst_ep", 32'(bus.ep), 32'd0);
        rst_n = 1'b1;

        // Framing strobes without in_valid must not advance the load.
        bus.col_end = 1'b1; bus.row_end = 1'b1; bus.in_data = 8'sh7f;
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();
        chk("strobe_without_valid", 32'(bus.busy), 32'd0);

        for (int t = 0; t < 7; t++) run_scenario(tbl[t]);

        // A rows of length 3 then 2: A malformed, visible as soon as it happens.
        push_illegal(2'b01);
        send_el(1, 1'b0, 1'b0); send_el(2, 1'b0, 1'b0); send_el(3, 1'b1, 1'b0);
        send_el(4, 1'b0, 1'b0); send_el(5, 1'b1, 1'b1);
        chk("ep_live", 32'(bus.ep), 32'd1);
        load_mat(2, 2, 1, 1);
        finish_run(1'b0, 3);

        // Abort mid-CALC, then a fresh 1x1 product.
        load_mat(4, 4, 1, 1);
        load_mat(4, 4, 2, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_is_legal", 32'(bus.is_legal), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        s = '{ar:1, ac:1, br:1, bc:1, a_base:-3, a_step:0, b_base:5, b_step:0, tog:1'b0, exp_ep:2'b00};
        run_scenario(s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
